// File: rtl/chunk_serial_addsub.sv
// chunk_serial_addsub: multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   start in   request a new operation (accepted in IDLE or DONE)
//   sub   in   0 = a+b, 1 = a-b
//   a, b  in   WIDTH-bit operands, sampled with start
//   busy  out  high while chunks are being processed
//   done  out  one-cycle pulse when sum/cout/ovf are updated
//   sum   out  WIDTH-bit result, held until the next done
//   cout  out  carry out of the MSB (for sub, 1 = no borrow)
//   ovf   out  two's-complement signed overflow
// Optional: define CHUNK_SERIAL_ADDSUB_SAT_EN to saturate sum on signed overflow.
module chunk_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, part_q, part_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [31:0]      base;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk, ovf_calc;
    logic [WIDTH-1:0] full;
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        base    = 32'(idx_q) * 32'(CHUNK);
        {c_chunk, s_chunk} = {1'b0, opa_q[base +: CHUNK]} + {1'b0, opb_q[base +: CHUNK]}
                           + {{CHUNK{1'b0}}, carry_q};
        // Partial result with the current chunk merged in; complete on the last chunk.
        full = part_q;
        full[base +: CHUNK] = s_chunk;
        ovf_calc = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (full[WIDTH-1] != opa_q[WIDTH-1]);
        if (state_q == RUN) begin
            part_d  = full;
            carry_d = c_chunk;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(N - 1)) begin
                state_d = DONE;
                cout_d  = c_chunk;
                ovf_d   = ovf_calc;
`ifdef CHUNK_SERIAL_ADDSUB_SAT_EN
                sum_d   = ovf_calc ? (opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}}) : full;
`else
                sum_d   = full;
`endif
            end
        end else if (start) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            state_d = RUN;
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            idx_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: doc/chunk_serial_addsub.md
Name: chunk_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor that supersedes the fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with the carry registered between chunks.
- Trades latency for area. Intended as the shared arithmetic unit behind the board-level lab datapaths.
- Provides start/busy/done handshaking plus carry-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per RUN cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Let N = WIDTH/CHUNK. FSM states are IDLE, RUN and DONE.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand, partial-result and carry registers are cleared.
- An operation in progress when reset is asserted is abandoned; no done pulse is produced for it.
- Start acceptance: start is accepted only in IDLE or DONE.
  - On acceptance, latch opA=a, opB=(sub ? ~b : b), carry=sub, chunk index=0. Go to RUN.
- start in RUN is ignored; the latched operands are unaffected.
- RUN, each edge:
  - Compute {c, s} = opA[chunk] + opB[chunk] + carry, using CHUNK+1-bit arithmetic.
  - Write s into the partial result at the chunk position, set carry=c, increment the index.
  - On the edge that processes chunk N-1, go to DONE and update the outputs:
    - sum = full result.
    - cout = final carry.
    - ovf = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]).
- Latency: done is high during the cycle that starts N rising edges after the accepting edge. For the defaults, done is high 4 cycles after start is sampled. busy is high for exactly N cycles.
- DONE lasts one cycle with done=1:
  - If start is also high, the new operation is accepted and the FSM returns to RUN. This gives back-to-back throughput of one result per N+1 cycles.
  - Otherwise the FSM returns to IDLE.
- sum, cout and ovf hold their values until the next DONE or a reset. They are never driven with partial values during RUN.
- Wrap-around: the result is modulo 2^WIDTH. Carry out of the MSB appears only on cout.
- When CHUNK == WIDTH, N=1 and the single RUN cycle produces the result.

Optional Feature:
- Macro: CHUNK_SERIAL_ADDSUB_SAT_EN.
- Defined: on DONE with ovf=1, sum is replaced by the signed saturation value. That is 0111..1 when opA[MSB]=0, and 1000..0 when opA[MSB]=1. ovf and cout still report the unsaturated result.
- Not defined: sum wraps modulo 2^WIDTH, with no saturation logic synthesised.

Test Plan (WIDTH=16, CHUNK=4):
- a=0x1234, b=0x0FFF, sub=0, one-cycle start -> busy high 4 cycles; done pulses 4 cycles after start; sum=0x2233, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; with SAT_EN, sum=0x7FFF.
- sub=1: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1; with SAT_EN, sum=0x8000.
- Start with a=0x0001, b=0x0001, then pulse start with a=0xAAAA in the 2nd RUN cycle -> ignored; sum=0x0002 and exactly one done pulse.
- Start an op, assert rst asynchronously in the 3rd RUN cycle -> busy, done, sum, cout and ovf go to 0 without waiting for a clock edge. After release, no done pulse until a new start.
- Hold start high continuously with changing operands -> results and done pulses every 5 cycles. Operands are sampled at each DONE cycle; no op is lost or duplicated.
